gas_station_multi: RTL

Parametrised multi-pump gas station controller and the successor to the single-pump gasStation.
- NUM_PUMPS independent pump FSMs, each with two fuel grades and per-grade unit pricing.
- Saturating credit accounting with change return.
- One shared car wash, allocated to pumps by a round-robin arbiter.
- Sits at station top level between the per-pump input panels (select, coin, start, tank sensor) and the dispenser, wash and change actuators.

---
 rtl/gas_station_multi.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/gas_station_multi.sv
// Multi-pump fuel controller: per-pump grade/credit FSMs plus one shared car wash behind a round-robin arbiter.
// Latency: inputs sampled on the rising edge, every output is registered and reflects that edge one cycle later.
// Backpressure: none; pulse inputs are consumed or ignored by state; wash requests wait until the washer is idle.
// Optional macro GAS_STATION_TOTALS_EN adds TOTAL_UNL/TOTAL_PREM/TOTAL_WASH lifetime counters.
module gas_station_multi #(
    parameter int NUM_PUMPS   = 4,
    parameter int CREDIT_W    = 8,
    parameter int PRICE_UNL   = 3,
    parameter int PRICE_PREM  = 4,
    parameter int WASH_COST   = 5,
    parameter int WASH_CYCLES = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PUMPS-1:0]            UNLEADED,
    input  logic [NUM_PUMPS-1:0]            PREMIUM,
    input  logic [NUM_PUMPS-1:0]            MONEY,
    input  logic [NUM_PUMPS-1:0]            START,
    input  logic [NUM_PUMPS-1:0]            TANKFULL,
    input  logic [NUM_PUMPS-1:0]            CARWASH_I,
    input  logic                            EMERGENCY_STOP,
    output logic [2*NUM_PUMPS-1:0]          state,
    output logic [NUM_PUMPS-1:0]            READY,
    output logic [NUM_PUMPS-1:0]            FEEDME,
    output logic [NUM_PUMPS-1:0]            DELIVERGAS,
    output logic [NUM_PUMPS-1:0]            CARWASH_O,
    output logic [NUM_PUMPS-1:0]            CHANGE_VALID,
    output logic [CREDIT_W*NUM_PUMPS-1:0]   CHANGE,
    output logic                            WASH_BUSY
`ifdef GAS_STATION_TOTALS_EN
    ,
    output logic [31:0]                     TOTAL_UNL,
    output logic [31:0]                     TOTAL_PREM,
    output logic [31:0]                     TOTAL_WASH
`endif
);

    localparam int PTR_W = (NUM_PUMPS > 1) ? $clog2(NUM_PUMPS) : 1;
    localparam int CNT_W = $clog2(WASH_CYCLES + 1);
    localparam logic [CREDIT_W:0] P_UNL  = (CREDIT_W+1)'(PRICE_UNL);
    localparam logic [CREDIT_W:0] P_PREM = (CREDIT_W+1)'(PRICE_PREM);
    localparam logic [CREDIT_W:0] C_WASH = (CREDIT_W+1)'(WASH_COST);

    typedef enum logic [1:0] {
        ST_READY   = 2'b00,
        ST_FEEDME  = 2'b01,
        ST_DELIVER = 2'b10,
        ST_WASH    = 2'b11
    } pump_st_t;

    pump_st_t                    r_state      [NUM_PUMPS];
    pump_st_t                    w_state_nxt  [NUM_PUMPS];
    logic [CREDIT_W-1:0]         r_credit     [NUM_PUMPS];
    logic [CREDIT_W-1:0]         w_credit_nxt [NUM_PUMPS];
    logic [NUM_PUMPS-1:0]        r_prem, w_prem_nxt;
    logic [NUM_PUMPS-1:0]        r_latch, w_latch_nxt;
    logic [NUM_PUMPS-1:0]        r_chg_vld, w_chg_vld_nxt;
    logic [CREDIT_W*NUM_PUMPS-1:0] r_chg, w_chg_nxt;
    logic [NUM_PUMPS-1:0]        w_req;

    logic                        r_busy, w_busy_nxt;
    logic [PTR_W-1:0]            r_owner, w_owner_nxt;
    logic [PTR_W-1:0]            r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
    logic                        w_gnt_vld;
    logic [PTR_W-1:0]            w_gnt_idx;
    logic                        w_wash_done;
`ifdef GAS_STATION_TOTALS_EN
    logic [NUM_PUMPS-1:0]        w_unl_ded, w_prem_ded;
`endif

    // Round-robin pick: lowest requesting index at or above the pointer, wrapping.
    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_PUMPS; i++) begin
            w_req[i] = (r_state[i] == ST_WASH);
        end
        // Walk offsets from farthest to nearest so the nearest requester is the last writer.
        for (int k = NUM_PUMPS - 1; k >= 0; k--) begin
            v_idx = (int'(r_ptr) + k) % NUM_PUMPS;
            if (w_req[PTR_W'(v_idx)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PTR_W'(v_idx);
            end
        end
        if (r_busy || EMERGENCY_STOP) begin
            w_gnt_vld = 1'b0;
        end
    end

    // Washer occupancy: count down WASH_CYCLES after a grant, abort on emergency stop.
    always_comb begin
        w_busy_nxt  = r_busy;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_wash_done = 1'b0;
        if (EMERGENCY_STOP) begin
            w_busy_nxt = 1'b0;
            w_cnt_nxt  = '0;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                w_busy_nxt  = 1'b0;
                w_wash_done = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end else if (w_gnt_vld) begin
            w_busy_nxt  = 1'b1;
            w_owner_nxt = w_gnt_idx;
            w_cnt_nxt   = CNT_W'(WASH_CYCLES - 1);
            w_ptr_nxt   = (w_gnt_idx == PTR_W'(NUM_PUMPS - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Per-pump next state, credit bookkeeping and change generation.
    always_comb begin
        logic                v_in_washer;
        logic                v_to_ready;
        logic [CREDIT_W:0]   v_price;
        logic [CREDIT_W:0]   v_reserve;
        logic [CREDIT_W:0]   v_credit;
        logic [CREDIT_W:0]   v_refund;
        v_in_washer   = 1'b0;
        v_to_ready    = 1'b0;
        v_price       = '0;
        v_reserve     = '0;
        v_credit      = '0;
        v_refund      = '0;
        w_prem_nxt    = r_prem;
        w_latch_nxt   = r_latch;
        w_chg_vld_nxt = '0;
        w_chg_nxt     = '0;
`ifdef GAS_STATION_TOTALS_EN
        w_unl_ded     = '0;
        w_prem_ded    = '0;
`endif
        for (int i = 0; i < NUM_PUMPS; i++) begin
            w_state_nxt[i]  = r_state[i];
            w_credit_nxt[i] = r_credit[i];
            v_in_washer     = r_busy && (r_owner == PTR_W'(i));
            v_price         = r_prem[i] ? P_PREM : P_UNL;
            v_reserve       = r_latch[i] ? C_WASH : '0;
            v_credit        = {1'b0, r_credit[i]};
            v_to_ready      = 1'b0;
            v_refund        = '0;
            if (EMERGENCY_STOP) begin
                if (r_state[i] != ST_READY) begin
                    v_to_ready = 1'b1;
                    // A car pulled out of the washer gets its wash fee back.
                    v_refund   = v_in_washer ? C_WASH : '0;
                end
            end else begin
                case (r_state[i])
                    ST_READY: begin
                        if (UNLEADED[i]) begin
                            w_state_nxt[i] = ST_FEEDME;
                            w_prem_nxt[i]  = 1'b0;
                        end else if (PREMIUM[i]) begin
                            w_state_nxt[i] = ST_FEEDME;
                            w_prem_nxt[i]  = 1'b1;
                        end
                    end
                    ST_FEEDME: begin
                        if (MONEY[i] && (r_credit[i] != '1)) begin
                            w_credit_nxt[i] = r_credit[i] + 1'b1;
                        end
                        if (CARWASH_I[i]) begin
                            w_latch_nxt[i] = 1'b1;
                        end
                        if (START[i] && (v_credit >= v_price)) begin
                            w_state_nxt[i] = ST_DELIVER;
                        end
                    end
                    ST_DELIVER: begin
                        // A late wash request only changes the reserve from the next edge on.
                        if (CARWASH_I[i]) begin
                            w_latch_nxt[i] = 1'b1;
                        end
                        if (!TANKFULL[i] && (v_credit >= v_price + v_reserve)) begin
                            w_credit_nxt[i] = r_credit[i] - v_price[CREDIT_W-1:0];
`ifdef GAS_STATION_TOTALS_EN
                            if (r_prem[i]) w_prem_ded[i] = 1'b1;
                            else           w_unl_ded[i]  = 1'b1;
`endif
                        end else if (r_latch[i] && (v_credit >= C_WASH)) begin
                            w_state_nxt[i] = ST_WASH;
                        end else begin
                            v_to_ready = 1'b1;
                        end
                    end
                    ST_WASH: begin
                        if (w_gnt_vld && (w_gnt_idx == PTR_W'(i))) begin
                            w_credit_nxt[i] = r_credit[i] - C_WASH[CREDIT_W-1:0];
                        end
                        if (v_in_washer && w_wash_done) begin
                            v_to_ready = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (v_to_ready) begin
                w_state_nxt[i]                       = ST_READY;
                w_chg_vld_nxt[i]                     = 1'b1;
                w_chg_nxt[i*CREDIT_W +: CREDIT_W]    = r_credit[i] + v_refund[CREDIT_W-1:0];
                w_credit_nxt[i]                      = '0;
                w_prem_nxt[i]                        = 1'b0;
                w_latch_nxt[i]                       = 1'b0;
            end
        end
    end

    // State, credit, washer and change registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PUMPS; i++) begin
                r_state[i]  <= ST_READY;
                r_credit[i] <= '0;
            end
            r_prem    <= '0;
            r_latch   <= '0;
            r_chg_vld <= '0;
            r_chg     <= '0;
            r_busy    <= 1'b0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
        end else begin
            for (int i = 0; i < NUM_PUMPS; i++) begin
                r_state[i]  <= w_state_nxt[i];
                r_credit[i] <= w_credit_nxt[i];
            end
            r_prem    <= w_prem_nxt;
            r_latch   <= w_latch_nxt;
            r_chg_vld <= w_chg_vld_nxt;
            r_chg     <= w_chg_nxt;
            r_busy    <= w_busy_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

`ifdef GAS_STATION_TOTALS_EN
    // Lifetime counters; emergency-aborted washes never reach w_wash_done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            TOTAL_UNL  <= '0;
            TOTAL_PREM <= '0;
            TOTAL_WASH <= '0;
        end else begin
            TOTAL_UNL  <= TOTAL_UNL  + 32'($countones(w_unl_ded));
            TOTAL_PREM <= TOTAL_PREM + 32'($countones(w_prem_ded));
            TOTAL_WASH <= TOTAL_WASH + {31'd0, w_wash_done};
        end
    end
`endif

    for (genvar g = 0; g < NUM_PUMPS; g++) begin : g_out
        assign state[2*g +: 2] = r_state[g];
        assign READY[g]        = (r_state[g] == ST_READY);
        assign FEEDME[g]       = (r_state[g] == ST_FEEDME);
        assign DELIVERGAS[g]   = (r_state[g] == ST_DELIVER);
        assign CARWASH_O[g]    = r_busy && (r_owner == PTR_W'(g));
    end

    assign CHANGE_VALID = r_chg_vld;
    assign CHANGE       = r_chg;
    assign WASH_BUSY    = r_busy;

endmodule
